// File: rtl/util_rpt.sv
// Window controller and report reader for the CA utilization monitor: pulses mon_upd every 2^WIN_SHIFT cycles, captures util one cycle later.
// Reports visible two cycles after mon_upd via a 2-entry valid/ready FIFO; a capture into a full FIFO with no pop is dropped and counted.
module util_rpt #(
    parameter int        WIN_SHIFT = 10,
    parameter logic [5:0] ALARM_TH = 6'd40
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mon_en,
    output logic            mon_upd,
    input  logic [7:0][5:0] aimc_ca_util,
    output logic            rpt_valid,
    input  logic            rpt_ready,
    output logic [63:0]     rpt_data,
    output logic            alarm_any,
    output logic [7:0][5:0] peak_util,
    input  logic            peak_clr,
    output logic [15:0]     drop_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // mon_upd is registered, so it is raised on the edge where win_cnt reaches its last value
    localparam logic [WIN_SHIFT-1:0] WIN_PRE = WIN_SHIFT'((1 << WIN_SHIFT) - 2);

    logic [1:0]           state;
    logic [WIN_SHIFT-1:0] win_cnt;
    logic                 upd_discard;
    logic                 cap_pend;
    logic [7:0]           seq;
    logic [63:0]          slot1;
    logic                 slot1_vld;

    logic [7:0]  alarm_w;
    logic [63:0] word;
    logic        pop;
    logic        push;
    logic        drop;

    always_comb begin
        alarm_w = '0;
        for (int i = 2; i < 8; i++) begin
            alarm_w[i] = (aimc_ca_util[i] >= ALARM_TH);
        end
    end

    assign word = {seq, aimc_ca_util, alarm_w};
    assign pop  = rpt_valid && rpt_ready;
    assign push = cap_pend && (!slot1_vld || pop);
    assign drop = cap_pend && !push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            win_cnt     <= '0;
            mon_upd     <= 1'b0;
            upd_discard <= 1'b0;
            cap_pend    <= 1'b0;
        end else begin
            mon_upd  <= 1'b0;
            cap_pend <= mon_upd && !upd_discard;
            case (state)
                ST_IDLE: begin
                    win_cnt <= '0;
                    if (mon_en) begin
                        state       <= ST_SYNC;
                        mon_upd     <= 1'b1;
                        upd_discard <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    state   <= ST_RUN;
                    win_cnt <= '0;
                end
                ST_RUN: begin
                    if (!mon_en) begin
                        state   <= ST_IDLE;
                        win_cnt <= '0;
                    end else begin
                        win_cnt <= win_cnt + WIN_SHIFT'(1);
                        if (win_cnt == WIN_PRE) begin
                            mon_upd     <= 1'b1;
                            upd_discard <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    win_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_valid <= 1'b0;
            rpt_data  <= '0;
            slot1     <= '0;
            slot1_vld <= 1'b0;
        end else if (pop) begin
            if (slot1_vld) begin
                rpt_data <= slot1;
                if (push) slot1 <= word;
                else      slot1_vld <= 1'b0;
            end else if (push) begin
                rpt_data <= word;
            end else begin
                rpt_valid <= 1'b0;
            end
        end else if (push) begin
            if (!rpt_valid) begin
                rpt_data  <= word;
                rpt_valid <= 1'b1;
            end else begin
                slot1     <= word;
                slot1_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq       <= '0;
            alarm_any <= 1'b0;
            drop_cnt  <= '0;
            peak_util <= '0;
        end else begin
            alarm_any <= cap_pend && (alarm_w != 8'd0);
            if (cap_pend) seq <= seq + 8'd1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            // a clear coinciding with a capture leaves exactly the captured values
            for (int i = 0; i < 8; i++) begin
                if (peak_clr) begin
                    peak_util[i] <= cap_pend ? aimc_ca_util[i] : 6'd0;
                end else if (cap_pend && aimc_ca_util[i] > peak_util[i]) begin
                    peak_util[i] <= aimc_ca_util[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_util_rpt.sv
// Randomized bench for util_rpt with a window-schedule / queue reference model.
module tb_util_rpt;
    localparam int WS  = 4;
    localparam int WIN = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mon_en = 1'b0;
    logic            mon_upd;
    logic [7:0][5:0] aimc_ca_util = '0;
    logic            rpt_valid;
    logic            rpt_ready = 1'b0;
    logic [63:0]     rpt_data;
    logic            alarm_any;
    logic [7:0][5:0] peak_util;
    logic            peak_clr = 1'b0;
    logic [15:0]     drop_cnt;

    util_rpt #(.WIN_SHIFT(WS), .ALARM_TH(6'd40)) dut (
        .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .mon_upd(mon_upd),
        .aimc_ca_util(aimc_ca_util), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_data(rpt_data), .alarm_any(alarm_any), .peak_util(peak_util),
        .peak_clr(peak_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit              drv_en = 0, drv_rdy = 0, drv_rdy_rand = 0, drv_fixed = 0, drv_pclr = 0;
    logic [7:0][5:0] fix_util = '0;

    // reference model: expected state of the cycle currently on the outputs
    logic [63:0]     m_q[$];
    logic [7:0][5:0] m_peak;
    logic [15:0]     m_drop;
    int              m_seq, m_start, m_cyc;
    bit              m_on, m_upd, m_disc, m_cap, m_alarm_any;
    bit              chk_on = 0;
    logic [63:0]     dut_pops[$];

    task automatic model_reset();
        m_q.delete();
        m_peak = '0; m_drop = '0; m_seq = 0; m_start = 0; m_cyc = 0;
        m_on = 0; m_upd = 0; m_disc = 0; m_cap = 0; m_alarm_any = 0;
    endtask

    // drive one cycle of inputs, predict the result of the coming edge, move to next negedge
    task automatic step();
        logic [7:0][5:0] u;
        logic [7:0]      al;
        bit              en, rdy, pc, next_cap;
        int              nc;
        en = drv_en;
        pc = drv_pclr;
        rdy = drv_rdy_rand ? bit'($urandom_range(0, 1)) : drv_rdy;
        for (int i = 0; i < 8; i++) u[i] = drv_fixed ? fix_util[i] : 6'($urandom_range(0, 63));
        mon_en = en; rpt_ready = rdy; peak_clr = pc; aimc_ca_util = u;
        if (rpt_valid === 1'b1 && rdy) dut_pops.push_back(rpt_data);

        nc = m_cyc + 1;
        m_alarm_any = 0;
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        al = '0;
        if (m_cap) begin
            for (int i = 2; i < 8; i++) if (int'(u[i]) >= 40) al[i] = 1'b1;
            if (m_q.size() < 2) m_q.push_back({8'(m_seq), u, al});
            else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            m_seq = (m_seq + 1) % 256;
            m_alarm_any = (al != 8'd0);
        end
        for (int i = 0; i < 8; i++) begin
            if (pc) m_peak[i] = m_cap ? u[i] : 6'd0;
            else if (m_cap && u[i] > m_peak[i]) m_peak[i] = u[i];
        end
        next_cap = m_upd && !m_disc;
        m_upd = 0;
        if (!m_on) begin
            if (en) begin m_on = 1; m_start = nc; m_upd = 1; m_disc = 1; end
        end else if (!en && nc != m_start + 1) begin
            m_on = 0;
        end else if (en && nc != m_start && ((nc - m_start) % WIN) == 0) begin
            m_upd = 1; m_disc = 0;
        end
        m_cap = next_cap;
        m_cyc = nc;
        @(negedge clk);
    endtask

    // scoreboard against the model, sampled shortly after each active edge
    always @(posedge clk) begin
        #2;
        if (chk_on && rst_n) begin
            total++;
            if (mon_upd !== m_upd) begin bad++; $display("FAIL mon_upd cyc=%0d got=%b exp=%b", m_cyc, mon_upd, m_upd); end
            total++;
            if (rpt_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rpt_valid cyc=%0d got=%b exp=%b", m_cyc, rpt_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                total++;
                if (rpt_data !== m_q[0]) begin bad++; $display("FAIL rpt_data cyc=%0d got=%h exp=%h", m_cyc, rpt_data, m_q[0]); end
            end
            total++;
            if (alarm_any !== m_alarm_any) begin bad++; $display("FAIL alarm_any cyc=%0d got=%b exp=%b", m_cyc, alarm_any, m_alarm_any); end
            total++;
            if (drop_cnt !== m_drop) begin bad++; $display("FAIL drop_cnt cyc=%0d got=%0d exp=%0d", m_cyc, drop_cnt, m_drop); end
            total++;
            if (peak_util !== m_peak) begin bad++; $display("FAIL peak_util cyc=%0d got=%h exp=%h", m_cyc, peak_util, m_peak); end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (mon_upd !== 1'b0)   begin bad++; $display("FAIL reset_mon_upd got=%b exp=0", mon_upd); end
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL reset_rpt_valid got=%b exp=0", rpt_valid); end
        total++; if (rpt_data !== 64'd0) begin bad++; $display("FAIL reset_rpt_data got=%h exp=0", rpt_data); end
        total++; if (alarm_any !== 1'b0) begin bad++; $display("FAIL reset_alarm_any got=%b exp=0", alarm_any); end
        total++; if (peak_util !== '0)   begin bad++; $display("FAIL reset_peak got=%h exp=0", peak_util); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        rst_n = 1'b1;
        model_reset();
        chk_on = 1;
    endtask

    task automatic test_enable();
        drv_en = 1; drv_rdy = 1;
        dut_pops.delete();
        step();
        total++; if (mon_upd !== 1'b1) begin bad++; $display("FAIL sync_pulse got=%b exp=1", mon_upd); end
        for (int j = 1; j <= 40; j++) begin
            step();
            total++;
            if (mon_upd !== ((j % WIN) == 0)) begin bad++; $display("FAIL upd_spacing j=%0d got=%b exp=%b", j, mon_upd, (j % WIN) == 0); end
        end
        total++;
        if (dut_pops.size() < 2) begin
            bad++; $display("FAIL enable_reports got=%0d exp>=2", dut_pops.size());
        end else begin
            if (dut_pops[0][63:56] !== 8'd0 || dut_pops[1][63:56] !== 8'd1) begin
                bad++; $display("FAIL enable_seq got=%0d,%0d exp=0,1", dut_pops[0][63:56], dut_pops[1][63:56]);
            end
        end
    endtask

    task automatic test_alarm();
        logic [7:0][5:0] pat;
        logic [63:0]     w;
        bit              saw;
        pat = {6'd40, 6'd39, 6'd63, 6'd0, 6'd41, 6'd5, 6'd0, 6'd0};
        fix_util = pat; drv_fixed = 1; saw = 0; dut_pops.delete();
        for (int j = 0; j < 18; j++) begin step(); if (alarm_any === 1'b1) saw = 1; end
        total++;
        if (dut_pops.size() == 0) begin
            bad++; $display("FAIL alarm_report got=none exp=one");
        end else begin
            w = dut_pops[dut_pops.size() - 1];
            if (w[7:0] !== 8'b1010_1000 || w[55:8] !== pat) begin
                bad++; $display("FAIL alarm_bits got=%b util=%h exp=10101000 util=%h", w[7:0], w[55:8], pat);
            end
        end
        total++; if (!saw) begin bad++; $display("FAIL alarm_any_pulse got=0 exp=1"); end
        fix_util = {8{6'd20}}; saw = 0; dut_pops.delete();
        for (int j = 0; j < 18; j++) begin step(); if (alarm_any === 1'b1) saw = 1; end
        total++;
        if (dut_pops.size() == 0) begin
            bad++; $display("FAIL quiet_report got=none exp=one");
        end else begin
            w = dut_pops[dut_pops.size() - 1];
            if (w[7:0] !== 8'd0) begin bad++; $display("FAIL quiet_bits got=%b exp=0", w[7:0]); end
        end
        total++; if (saw) begin bad++; $display("FAIL quiet_alarm_any got=1 exp=0"); end
        drv_fixed = 0;
    endtask

    task automatic test_disable();
        int n_upd, guard;
        guard = 0;
        while (!(m_upd && !m_disc) && guard < 40) begin step(); guard++; end
        total++; if (guard >= 40) begin bad++; $display("FAIL disable_wait got=timeout exp=pulse"); end
        step();
        drv_en = 0; dut_pops.delete(); n_upd = 0;
        for (int j = 0; j < 40; j++) begin step(); if (mon_upd === 1'b1) n_upd++; end
        total++; if (n_upd != 0) begin bad++; $display("FAIL disable_no_upd got=%0d exp=0", n_upd); end
        total++; if (dut_pops.size() != 1) begin bad++; $display("FAIL disable_last_report got=%0d exp=1", dut_pops.size()); end
        drv_en = 1;
        step();
        total++; if (mon_upd !== 1'b1) begin bad++; $display("FAIL reenable_sync got=%b exp=1", mon_upd); end
    endtask

    task automatic test_peak_clr();
        int guard;
        guard = 0;
        while (!m_cap && guard < 40) begin step(); guard++; end
        total++; if (guard >= 40) begin bad++; $display("FAIL peak_wait got=timeout exp=capture"); end
        drv_pclr = 1; drv_fixed = 1; fix_util = {8{6'd10}};
        step();
        drv_pclr = 0; drv_fixed = 0;
        step();
        total++; if (peak_util !== {8{6'd10}}) begin bad++; $display("FAIL peak_clr_capture got=%h exp=%h", peak_util, {8{6'd10}}); end
        drv_pclr = 1;
        step();
        drv_pclr = 0;
        step();
        total++;
        if (!m_cap && peak_util !== '0) begin bad++; $display("FAIL peak_clr_only got=%h exp=0", peak_util); end
    endtask

    task automatic test_reset_mid();
        int guard;
        drv_rdy = 0; guard = 0;
        while (m_q.size() < 2 && guard < 60) begin step(); guard++; end
        repeat (3) step();
        total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_full got=%b exp=1", rpt_valid); end
        chk_on = 0;
        rst_n = 1'b0;
        #1;
        total++; if (mon_upd !== 1'b0)   begin bad++; $display("FAIL areset_mon_upd got=%b exp=0", mon_upd); end
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL areset_rpt_valid got=%b exp=0", rpt_valid); end
        total++; if (rpt_data !== 64'd0) begin bad++; $display("FAIL areset_rpt_data got=%h exp=0", rpt_data); end
        total++; if (peak_util !== '0)   begin bad++; $display("FAIL areset_peak got=%h exp=0", peak_util); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL areset_drop got=%0d exp=0", drop_cnt); end
        drv_en = 0; mon_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk_on = 1;
    endtask

    task automatic test_backpressure();
        drv_en = 1; drv_rdy = 0;
        for (int j = 0; j < 70; j++) step();
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL bp_drop got=%0d exp=2", drop_cnt); end
        total++; if (rpt_data[63:56] !== 8'd0) begin bad++; $display("FAIL bp_head_seq got=%0d exp=0", rpt_data[63:56]); end
        drv_rdy = 1; dut_pops.delete();
        for (int j = 0; j < 20; j++) step();
        total++;
        if (dut_pops.size() != 3) begin
            bad++; $display("FAIL bp_release_count got=%0d exp=3", dut_pops.size());
        end else if (dut_pops[0][63:56] !== 8'd0 || dut_pops[1][63:56] !== 8'd1 || dut_pops[2][63:56] !== 8'd4) begin
            bad++; $display("FAIL bp_release_seq got=%0d,%0d,%0d exp=0,1,4", dut_pops[0][63:56], dut_pops[1][63:56], dut_pops[2][63:56]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d0;
        int guard;
        drv_rdy = 0; guard = 0;
        while (m_q.size() < 2 && guard < 40) begin step(); guard++; end
        while (!m_cap && guard < 80) begin step(); guard++; end
        total++; if (guard >= 80) begin bad++; $display("FAIL b2b_wait got=timeout exp=full+capture"); end
        d0 = drop_cnt;
        drv_rdy = 1; dut_pops.delete();
        for (int j = 0; j < 20; j++) step();
        total++; if (drop_cnt !== d0) begin bad++; $display("FAIL b2b_drop got=%0d exp=%0d", drop_cnt, d0); end
        total++;
        if (dut_pops.size() < 3) begin
            bad++; $display("FAIL b2b_count got=%0d exp>=3", dut_pops.size());
        end else if (dut_pops[1][63:56] !== dut_pops[0][63:56] + 8'd1 || dut_pops[2][63:56] !== dut_pops[1][63:56] + 8'd1) begin
            bad++; $display("FAIL b2b_order got=%0d,%0d,%0d exp=consecutive", dut_pops[0][63:56], dut_pops[1][63:56], dut_pops[2][63:56]);
        end
    endtask

    task automatic test_random();
        drv_rdy_rand = 1;
        for (int j = 0; j < 800; j++) begin
            if ($urandom_range(0, 49) == 0) drv_en = !drv_en;
            drv_pclr = ($urandom_range(0, 29) == 0);
            step();
        end
        drv_pclr = 0; drv_rdy_rand = 0;
    endtask

    initial begin
        test_reset();
        test_enable();
        test_alarm();
        test_disable();
        test_peak_clr();
        test_reset_mid();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/util_rpt.md
# util_rpt

Window controller and report reader for the AiM CA utilization monitor. Owns the averaging window: it pulses `mon_upd` once every 2^WIN_SHIFT cycles, then captures the eight 6-bit `aimc_ca_util` values one cycle later. Each capture becomes a sequenced report word carrying threshold-alarm flags. Report words are buffered in a 2-entry FIFO and drained over a valid/ready stream toward the host register/telemetry path. The block also tracks per-category peaks and a dropped-report counter.

## Interface
- `WIN_SHIFT`, default 10: window = 2^WIN_SHIFT cycles. Must equal the monitor's averaging shift (`AVG_SHIFT`).
- `ALARM_TH`, default 6'd40: alarm threshold, applied to categories 7..2.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mon_en` in 1: level enable for windowing.
- `mon_upd` out 1: one-cycle window-close/clear pulse to the utilization monitor.
- `aimc_ca_util` in [7:0][5:0]: utilization values from the monitor. Valid in the cycle after `mon_upd`.
- `rpt_valid` out 1: FIFO head valid.
- `rpt_ready` in 1: consumer accept.
- `rpt_data` out 64: `{seq[7:0], util[47:0] (cat7 in MSBs), alarm[7:0]}`.
- `alarm_any` out 1: one-cycle pulse when a captured window has any alarm bit set.
- `peak_util` out [7:0][5:0]: per-category maximum since reset or the last `peak_clr`.
- `peak_clr` in 1: synchronous clear of `peak_util`.
- `drop_cnt` out 16: count of reports lost to a full FIFO. Saturates at 16'hFFFF.

## Operation
- FSM states:
  - IDLE: `mon_en` low. Window counter held at 0.
  - SYNC: single cycle, entered on the rising edge of `mon_en`. Drives `mon_upd`=1 to flush a stale partial window. This pulse is marked discard and causes no capture.
  - RUN: window counter `win_cnt` (WIN_SHIFT bits) increments every cycle. When `win_cnt` = 2^WIN_SHIFT−1, drive `mon_upd`=1 and arm capture; `win_cnt` wraps to 0.
- Transitions:
  - IDLE→SYNC when `mon_en`=1.
  - SYNC→RUN unconditionally, with `win_cnt` starting at 0.
  - RUN→IDLE as soon as `mon_en`=0. `win_cnt` clears to 0 and no further `mon_upd` is issued.
- Capture happens in the cycle after a non-discard `mon_upd`:
  - Build the word. `alarm[i]` = (`aimc_ca_util[i]` ≥ ALARM_TH) for i=7..2. `alarm[1:0]`=0.
  - `seq` is an 8-bit counter that increments on every capture, including dropped ones, and wraps 255→0.
  - Push the word into the FIFO. If the FIFO is full and no pop happens in the same cycle, drop the word and increment `drop_cnt` (saturating).
  - Update `peak_util[i]` = max(`peak_util[i]`, `aimc_ca_util[i]`) for all 8 categories.
  - Pulse `alarm_any` if any alarm bit is set.
- FIFO:
  - Depth 2. Pop on `rpt_valid && rpt_ready`.
  - A push and a pop in the same cycle while full are both accepted; no drop occurs.
  - `rpt_data` holds the head entry. It is stable while `rpt_valid && !rpt_ready`.
- `peak_clr` coinciding with a capture: the clear wins for that cycle, then `peak_util` loads the captured values.
- A capture armed just before `mon_en` falls still completes.
- FIFO contents, `seq`, `peak_util` and `drop_cnt` persist across enable toggles.
- All arithmetic is unsigned. Util values are treated as raw 6-bit quantities with no clamping.

## Timing
- Reset state: `mon_upd`=0, `rpt_valid`=0, `rpt_data`=0, `alarm_any`=0, `peak_util`=0, `drop_cnt`=0, `seq`=0, FSM=IDLE, `win_cnt`=0.
- `mon_en` rises before edge E0: SYNC `mon_upd` is high in the cycle after E0. The first RUN `mon_upd` follows exactly 2^WIN_SHIFT cycles later. Subsequent pulses are spaced exactly 2^WIN_SHIFT cycles apart.
- `mon_upd` high in cycle T:
  - `aimc_ca_util` is sampled at the end of T+1.
  - `rpt_valid` is high in T+2 if the FIFO was empty.
  - `alarm_any` pulses in T+2.
  - `peak_util` and `drop_cnt` update visibly in T+2.
- Pop-to-next-head latency: 0. The second entry is presented in the cycle after the accepting edge.
- All outputs are registered.

## Test plan
- Enable with WIN_SHIFT=4: the SYNC pulse occurs one cycle after `mon_en` is sampled high, then `mon_upd` fires every 16 cycles. Only non-SYNC pulses produce reports, with `seq` = 0, 1, 2, ...
- Drive `aimc_ca_util` = {40,39,63,0,41,5,0,0} (cat7..0) in the capture cycle: expect `alarm`=8'b1010_1000 and an `alarm_any` pulse. The next window with all values <40 gives `alarm`=0 and no pulse.
- Hold `rpt_ready`=0 for 4 windows: 2 reports are kept (seq 0, 1) and `drop_cnt`=2. After releasing `rpt_ready`, the next report has seq=4.
- FIFO full with a capture and `rpt_ready`=1 in the same cycle: no drop, `drop_cnt` unchanged, order preserved.
- Deassert `mon_en` in the cycle after `mon_upd`: that capture still reports, no further `mon_upd` occurs, and re-enabling produces a fresh SYNC pulse.
- Assert `rst_n` low mid-window with a full FIFO: all outputs go to reset values asynchronously. Assert `peak_clr` together with a capture of value 10: `peak_util` equals 10 afterwards.
